// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter owning a shared 4:1 mux; optional burst limit under MUX4_RR_ARB_BURST_EN.
// Grant, select and mux output are all registered; reset is asynchronous active-high.
module mux4_rr_arb #(
  parameter int unsigned BURST_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       in0,
  input  logic       in1,
  input  logic       in2,
  input  logic       in3,
  output logic [3:0] grant,
  output logic [1:0] sel,
  output logic       out,
  output logic       out_vld,
  output logic       busy
);

  localparam int unsigned N     = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     grant_q, grant_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic             out_q, out_d;
  logic             out_vld_q, out_vld_d;
  logic             busy_q, busy_d;
  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [N-1:0]     din;

`ifdef MUX4_RR_ARB_BURST_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             others_pending;
`else
  logic [CNT_W-1:0] burst_unused;
  assign burst_unused = CNT_W'(BURST_MAX);
`endif

  assign din = {in3, in2, in1, in0};

  // First requester in order last+1, last+2, last+3, last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    win_found = 1'b0;
    win_idx   = last_q;
    cand      = '0;
    for (int k = 1; k <= int'(N); k++) begin
      cand = last_q + IDX_W'(k);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    last_d    = last_q;
`ifdef MUX4_RR_ARB_BURST_EN
    cnt_d          = cnt_q;
    others_pending = |(req & ~grant_q);
`endif
    out_d     = (state_q == OWN) ? din[sel_q] : 1'b0;
    out_vld_d = (state_q == OWN);

    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = OWN;
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          last_d  = win_idx;
`ifdef MUX4_RR_ARB_BURST_EN
          cnt_d   = CNT_W'(1);
`endif
        end
      end
      OWN: begin
        if (req == '0) begin
          state_d = IDLE;
          grant_d = '0;
`ifdef MUX4_RR_ARB_BURST_EN
          cnt_d   = '0;
`endif
        end else if (!req[sel_q]) begin
          grant_d = 4'b0001 << win_idx;
          sel_d   = win_idx;
          last_d  = win_idx;
`ifdef MUX4_RR_ARB_BURST_EN
          cnt_d   = CNT_W'(1);
`endif
        end else begin
`ifdef MUX4_RR_ARB_BURST_EN
          // Owner is last, so the search reaches any other requester before the owner.
          if (cnt_q == CNT_W'(BURST_MAX)) begin
            cnt_d = CNT_W'(1);
            if (others_pending) begin
              grant_d = 4'b0001 << win_idx;
              sel_d   = win_idx;
              last_d  = win_idx;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == OWN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      sel_q     <= '0;
      last_q    <= IDX_W'(3);
      out_q     <= 1'b0;
      out_vld_q <= 1'b0;
      busy_q    <= 1'b0;
`ifdef MUX4_RR_ARB_BURST_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
      busy_q    <= busy_d;
`ifdef MUX4_RR_ARB_BURST_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign grant   = grant_q;
  assign sel     = sel_q;
  assign out     = out_q;
  assign out_vld = out_vld_q;
  assign busy    = busy_q;

endmodule
